// File: rtl/mig_seq_eval_pkg.sv
// Shared types for the sequential majority-inverter-graph evaluator:
// operand and gate-word layouts, the FSM state encoding and the majority helper.
package mig_pkg;

  // Wide enough for any node index this block is ever configured with;
  // narrower operand fields are zero-extended on decode.
  localparam int MIG_IDX_W = 16;

  typedef struct packed {
    logic                 inv;
    logic [MIG_IDX_W-1:0] idx;
  } mig_operand_t;

  typedef struct packed {
    mig_operand_t op_c;
    mig_operand_t op_b;
    mig_operand_t op_a;
  } mig_gate_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } mig_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/mig_seq_eval_node_mux.sv
// Node selector: returns the value of one graph node (constant 0, a primary
// input or a gate result) given its index. Unknown indices read as 0.
module mig_node_mux
  import mig_pkg::*;
#(
  parameter int N_IN    = 7,
  parameter int N_GATES = 16
) (
  input  logic [MIG_IDX_W-1:0] i_idx,
  input  logic [N_IN-1:0]      i_x,
  input  logic [N_GATES-1:0]   i_gates,
  output logic                 o_val
);

  // Index 0 and anything past the last gate fall through to the 0 default.
  always_comb begin
    o_val = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      if (i_idx == MIG_IDX_W'(k + 1)) o_val = i_x[k];
    end
    for (int k = 0; k < N_GATES; k++) begin
      if (i_idx == MIG_IDX_W'(N_IN + 1 + k)) o_val = i_gates[k];
    end
  end

endmodule

// File: rtl/mig_seq_eval.sv
// Programmable majority-inverter-graph evaluator. A loaded gate program is
// executed one gate per cycle for each accepted input vector, and the selected
// node is returned as a single registered result bit.
module mig_seq_eval
  import mig_pkg::*;
#(
  parameter int N_IN    = 7,
  parameter int N_GATES = 16,
  parameter int NW      = $clog2(1 + N_IN + N_GATES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         prog_we,
  input  logic [$clog2(N_GATES)-1:0]   prog_addr,
  input  logic [3*(NW+1)-1:0]          prog_data,
  input  logic                         cfg_we,
  input  logic [$clog2(N_GATES+1)-1:0] cfg_num_gates,
  input  logic [NW-1:0]                cfg_out_sel,
  output logic                         prog_ready,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_IN-1:0]              x,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         y
);

  localparam int GW  = $clog2(N_GATES);
  localparam int CW  = $clog2(N_GATES + 1);
  localparam int OPW = NW + 1;

  mig_state_t           r_state;
  mig_state_t           w_nextState;
  logic [N_IN-1:0]      r_x;
  logic [N_GATES-1:0]   r_gateVal;
  logic [3*OPW-1:0]     r_mem [N_GATES];
  logic [CW-1:0]        r_numGates;
  logic [NW-1:0]        r_outSel;
  logic [GW-1:0]        r_g;
  logic                 r_y;

  logic                 w_idle;
  logic [CW-1:0]        w_cfgClamp;
  logic [CW-1:0]        w_numEff;
  logic [NW-1:0]        w_selEff;
  logic                 w_lastGate;
  logic                 w_enterDone;
  logic [3*OPW-1:0]     w_word;
  mig_gate_t            w_gate;
  logic                 w_valA;
  logic                 w_valB;
  logic                 w_valC;
  logic                 w_gateOut;
  logic [N_GATES-1:0]   w_nextGates;
  logic [N_IN-1:0]      w_outX;
  logic [N_GATES-1:0]   w_outGates;
  logic [MIG_IDX_W-1:0] w_outIdx;
  logic                 w_outVal;

  function automatic mig_operand_t decodeOp(input logic [OPW-1:0] f);
    mig_operand_t o;
    o.inv = f[NW];
    o.idx = MIG_IDX_W'(f[NW-1:0]);
    return o;
  endfunction

  // Effective configuration: a config write in IDLE applies to a vector
  // accepted in the same cycle, so the datapath looks through the write.
  always_comb begin
    w_idle     = (r_state == ST_IDLE);
    w_cfgClamp = (cfg_num_gates > CW'(N_GATES)) ? CW'(N_GATES) : cfg_num_gates;
    w_numEff   = (w_idle && cfg_we) ? w_cfgClamp : r_numGates;
    w_selEff   = (w_idle && cfg_we) ? cfg_out_sel : r_outSel;
    w_lastGate = (CW'(r_g) == (r_numGates - CW'(1)));
  end

  // Decode the gate word currently being executed into its three operands.
  always_comb begin
    w_word      = r_mem[r_g];
    w_gate.op_a = decodeOp(w_word[OPW-1:0]);
    w_gate.op_b = decodeOp(w_word[2*OPW-1:OPW]);
    w_gate.op_c = decodeOp(w_word[3*OPW-1:2*OPW]);
  end

  mig_node_mux #(.N_IN(N_IN), .N_GATES(N_GATES)) u_muxA (
    .i_idx(w_gate.op_a.idx), .i_x(r_x), .i_gates(r_gateVal), .o_val(w_valA)
  );
  mig_node_mux #(.N_IN(N_IN), .N_GATES(N_GATES)) u_muxB (
    .i_idx(w_gate.op_b.idx), .i_x(r_x), .i_gates(r_gateVal), .o_val(w_valB)
  );
  mig_node_mux #(.N_IN(N_IN), .N_GATES(N_GATES)) u_muxC (
    .i_idx(w_gate.op_c.idx), .i_x(r_x), .i_gates(r_gateVal), .o_val(w_valC)
  );

  // Current gate result, merged into the gate vector as it will look after
  // this cycle so the result mux can see the final gate on entry to DONE.
  always_comb begin
    w_gateOut = maj3(w_valA ^ w_gate.op_a.inv,
                     w_valB ^ w_gate.op_b.inv,
                     w_valC ^ w_gate.op_c.inv);
    w_nextGates      = r_gateVal;
    w_nextGates[r_g] = w_gateOut;
  end

  // Result source: when leaving IDLE directly the freshly accepted vector and
  // cleared gates apply; when leaving EVAL the updated gate vector applies.
  always_comb begin
    w_outX     = w_idle ? x : r_x;
    w_outGates = w_idle ? '0 : w_nextGates;
    w_outIdx   = MIG_IDX_W'(w_selEff);
  end

  mig_node_mux #(.N_IN(N_IN), .N_GATES(N_GATES)) u_muxOut (
    .i_idx(w_outIdx), .i_x(w_outX), .i_gates(w_outGates), .o_val(w_outVal)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  // FSM next-state logic.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) w_nextState = (w_numEff == '0) ? ST_DONE : ST_EVAL;
      end
      ST_EVAL: begin
        if (w_lastGate) w_nextState = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
    w_enterDone = (w_nextState == ST_DONE) && (r_state != ST_DONE);
  end

  // FSM outputs.
  always_comb begin
    prog_ready = (r_state == ST_IDLE);
    in_ready   = (r_state == ST_IDLE);
    out_valid  = (r_state == ST_DONE);
    y          = r_y;
  end

  // Gate program memory; writes land only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_GATES; k++) r_mem[k] <= '0;
    end else if (w_idle && prog_we && (int'(prog_addr) < N_GATES)) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  // Configuration registers; writes land only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_numGates <= '0;
      r_outSel   <= '0;
    end else if (w_idle && cfg_we) begin
      r_numGates <= w_cfgClamp;
      r_outSel   <= cfg_out_sel;
    end
  end

  // Evaluation datapath: latch the vector, step through gates, capture result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x       <= '0;
      r_gateVal <= '0;
      r_g       <= '0;
      r_y       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_x       <= x;
            r_gateVal <= '0;
            r_g       <= '0;
          end
        end
        ST_EVAL: begin
          r_gateVal <= w_nextGates;
          r_g       <= r_g + GW'(1);
        end
        default: begin
        end
      endcase
      if (w_enterDone) r_y <= w_outVal;
    end
  end

endmodule

// File: tb/tb_mig_seq_eval.sv
// Self-checking bench for mig_seq_eval: directed scenarios with hand-derived
// results plus random programs checked against a node-array reference model.
module tb_mig_seq_eval;

  localparam int N_IN    = 7;
  localparam int N_GATES = 16;
  localparam int NW      = 5;
  localparam int OPW     = NW + 1;
  localparam int GW      = 4;
  localparam int CW      = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               prog_we;
  logic [GW-1:0]      prog_addr;
  logic [3*OPW-1:0]   prog_data;
  logic               cfg_we;
  logic [CW-1:0]      cfg_num_gates;
  logic [NW-1:0]      cfg_out_sel;
  logic               prog_ready;
  logic               in_valid;
  logic               in_ready;
  logic [N_IN-1:0]    x;
  logic               out_valid;
  logic               out_ready;
  logic               y;

  int compared   = 0;
  int mismatched = 0;

  int               mdlNum;
  int               mdlSel;
  logic [3*OPW-1:0] mdlMem [N_GATES];

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  mig_seq_eval #(.N_IN(N_IN), .N_GATES(N_GATES)) dut (
    .clk(clk), .rst(rst),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .cfg_we(cfg_we), .cfg_num_gates(cfg_num_gates), .cfg_out_sel(cfg_out_sel),
    .prog_ready(prog_ready),
    .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .y(y)
  );

  // Absolute safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] global timeout");
  end

  function automatic logic [OPW-1:0] op(input int inv, input int idx);
    logic [OPW-1:0] r;
    r = {inv[0], idx[NW-1:0]};
    return r;
  endfunction

  function automatic logic [3*OPW-1:0] word3(input logic [OPW-1:0] a,
                                             input logic [OPW-1:0] b,
                                             input logic [OPW-1:0] c);
    return {c, b, a};
  endfunction

  function automatic int nx(input int i);
    return i + 1;
  endfunction

  function automatic int ng(input int g);
    return N_IN + 1 + g;
  endfunction

  // Reference: an array of node values, every gate is a vote of its three
  // (optionally inverted) operands; unwritten nodes stay 0.
  function automatic int modelEval(input logic [N_IN-1:0] xv);
    int vals[64];
    int ones;
    int f;
    int idx;
    int inv;
    for (int i = 0; i < 64; i++) vals[i] = 0;
    for (int i = 0; i < N_IN; i++) vals[i + 1] = int'(xv[i]);
    for (int g = 0; g < mdlNum; g++) begin
      ones = 0;
      for (int k = 0; k < 3; k++) begin
        f   = int'(mdlMem[g] >> (OPW * k)) & ((1 << OPW) - 1);
        idx = f % (1 << NW);
        inv = f / (1 << NW);
        ones += (idx <= N_IN + N_GATES ? vals[idx] : 0) ^ inv;
      end
      vals[ng(g)] = (ones >= 2) ? 1 : 0;
    end
    return (mdlSel <= N_IN + N_GATES) ? vals[mdlSel] : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic writeGate(input int addr, input logic [3*OPW-1:0] w);
    prog_we   = 1'b1;
    prog_addr = GW'(addr);
    prog_data = w;
    tick();
    prog_we = 1'b0;
    mdlMem[addr] = w;
  endtask

  task automatic writeCfg(input int n, input int sel);
    cfg_we        = 1'b1;
    cfg_num_gates = CW'(n);
    cfg_out_sel   = NW'(sel);
    tick();
    cfg_we = 1'b0;
    mdlNum = (n > N_GATES) ? N_GATES : n;
    mdlSel = sel;
  endtask

  // Present one vector and wait (bounded) for its result; out_ready stays low.
  task automatic applyStimulus(input logic [N_IN-1:0] xv, output logic yv, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      tick();
      guard++;
    end
    in_valid = 1'b1;
    x        = xv;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    yv = y;
  endtask

  task automatic releaseOutput();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic runCheck(input string tag, input logic [N_IN-1:0] xv,
                          input int expY, input int expLat);
    logic yv;
    int   lat;
    applyStimulus(xv, yv, lat);
    checkOutput({tag, "_lat"}, lat, expLat);
    checkOutput({tag, "_y"}, {31'd0, yv}, expY);
    releaseOutput();
    checkOutput({tag, "_inrdy"}, {31'd0, in_ready}, 1);
  endtask

  initial begin
    logic yv;
    int   lat;
    logic [3*OPW-1:0] rw;

    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    cfg_we = 1'b0; cfg_num_gates = '0; cfg_out_sel = '0;
    in_valid = 1'b0; x = '0; out_ready = 1'b0;
    mdlNum = 0; mdlSel = 0;
    for (int i = 0; i < N_GATES; i++) mdlMem[i] = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset defaults.
    checkOutput("rst_in_ready", {31'd0, in_ready}, 1);
    checkOutput("rst_prog_ready", {31'd0, prog_ready}, 1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 0);
    checkOutput("rst_y", {31'd0, y}, 0);
    runCheck("default_7f", 7'h7F, 0, 0);

    // Six-gate program from the reference network.
    writeGate(0, word3(op(0, nx(0)), op(0, nx(2)), op(0, nx(5))));
    writeGate(1, word3(op(0, nx(2)), op(0, nx(6)), op(0, ng(0))));
    writeGate(2, word3(op(0, nx(1)), op(0, nx(4)), op(0, ng(0))));
    writeGate(3, word3(op(0, nx(0)), op(0, nx(1)), op(0, ng(2))));
    writeGate(4, word3(op(0, nx(6)), op(0, ng(1)), op(0, ng(2))));
    writeGate(5, word3(op(0, nx(3)), op(0, ng(3)), op(0, ng(4))));
    writeCfg(6, ng(5));
    runCheck("net6_0001011", 7'b0001011, 1, 6);
    runCheck("net6_0000011", 7'b0000011, 0, 6);
    runCheck("net6_zero", 7'b0000000, 0, 6);

    // Backpressure: result held, writes during DONE are dropped.
    applyStimulus(7'b0001011, yv, lat);
    checkOutput("bp_lat", lat, 6);
    checkOutput("bp_y0", {31'd0, yv}, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        prog_we = 1'b1; prog_addr = 4'd5;
        prog_data = word3(op(1, nx(3)), op(1, ng(3)), op(1, ng(4)));
      end
      if (i == 5) begin
        cfg_we = 1'b1; cfg_num_gates = '0; cfg_out_sel = '0;
      end
      tick();
      prog_we = 1'b0;
      cfg_we  = 1'b0;
      checkOutput("bp_out_valid", {31'd0, out_valid}, 1);
      checkOutput("bp_y", {31'd0, y}, 1);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 0);
      checkOutput("bp_prog_ready", {31'd0, prog_ready}, 0);
    end
    releaseOutput();
    runCheck("bp_readback", 7'b0001011, 1, 6);

    // Inversion: OR of x1,x2 via an inverted constant operand.
    writeGate(0, word3(op(0, nx(1)), op(0, nx(2)), op(1, 0)));
    writeCfg(1, ng(0));
    runCheck("or_x1", 7'b0000010, 1, 1);
    runCheck("or_zero", 7'b0000000, 0, 1);

    // Simultaneous program write and accept: NOR takes effect immediately.
    rw = word3(op(1, nx(1)), op(1, nx(2)), op(0, 0));
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = rw;
    in_valid = 1'b1; x = 7'b0000000;
    tick();
    prog_we = 1'b0; in_valid = 1'b0;
    mdlMem[0] = rw;
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    checkOutput("nor_same_cycle_lat", lat, 1);
    checkOutput("nor_same_cycle_y", {31'd0, y}, 1);
    releaseOutput();
    runCheck("nor_x2", 7'b0000100, 0, 1);

    // Forward reference reads a not-yet-evaluated gate as 0.
    writeGate(0, word3(op(0, ng(1)), op(1, 0), op(0, nx(0))));
    writeGate(1, word3(op(1, 0), op(1, 0), op(0, 0)));
    writeCfg(2, ng(0));
    runCheck("fwd_x0_1", 7'b0000001, 1, 2);
    runCheck("fwd_x0_0", 7'b1111110, 0, 2);
    writeCfg(2, ng(1));
    runCheck("fwd_g1", 7'b0000000, 1, 2);

    // Clamp and out-of-range selection.
    writeCfg(31, 31);
    runCheck("clamp_sel31", 7'h55, 0, N_GATES);

    // Random programs against the reference model.
    for (int it = 0; it < 12; it++) begin
      writeCfg($urandom_range(0, 20), $urandom_range(0, 31));
      for (int g = 0; g < N_GATES; g++) writeGate(g, (3*OPW)'($urandom));
      for (int v = 0; v < 3; v++) begin
        logic [N_IN-1:0] xv;
        xv = N_IN'($urandom);
        runCheck("rand", xv, modelEval(xv), mdlNum);
      end
    end

    // Reset in the middle of an evaluation.
    writeCfg(16, ng(15));
    in_valid = 1'b1; x = 7'h7F;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mdlNum = 0; mdlSel = 0;
    for (int i = 0; i < N_GATES; i++) mdlMem[i] = '0;
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 0);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 1);
    runCheck("midrst_after", 7'h7F, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mig_seq_eval.md
# mig_seq_eval

Programmable, sequential majority-inverter-graph evaluator: a parametrised generalisation of our fixed 7-input majority networks. A gate program of up to N_GATES three-input majority gates with per-operand inversion is loaded through a write port. Each accepted input vector is then evaluated one gate per cycle, and a single result bit is returned over a valid/ready handshake. The block sits between the stimulus generator and the classification scoreboard, so any N_IN-input function can be swapped in without resynthesis.

## Interface
- N_IN, default 7: number of primary inputs.
- N_GATES, default 16: maximum gates per program.
- NW, default $clog2(1+N_IN+N_GATES): node-index width. Node 0 = constant 0; nodes 1..N_IN = x[i-1]; node N_IN+1+g = gate g.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- prog_we  in  1  gate-word write strobe; accepted only when prog_ready=1.
- prog_addr  in  $clog2(N_GATES)  gate index.
- prog_data  in  3*(NW+1)  three operand fields of {inv, idx[NW-1:0]}. Operand a is in the LSBs.
- cfg_we  in  1  config write strobe; accepted only when prog_ready=1.
- cfg_num_gates  in  $clog2(N_GATES+1)  number of gates to execute.
- cfg_out_sel  in  NW  node driven to the result.
- prog_ready  out  1  high in IDLE only.
- in_valid / in_ready  in/out  1  input-vector handshake.
- x  in  N_IN  input vector.
- out_valid / out_ready  out/in  1  result handshake.
- y  out  1  result bit; valid while out_valid=1.

## Operation
- FSM states: IDLE, EVAL, DONE.
- IDLE: in_ready=1 and prog_ready=1. On in_valid, x is latched, all gate-value flops are cleared, and the gate counter g is set to 0.
  - If num_gates=0, go to DONE.
  - Otherwise go to EVAL.
- EVAL: each cycle computes gate g = MAJ(a^ia, b^ib, c^ic) from the operand nodes and stores it. When g=num_gates-1, go to DONE; otherwise g increments.
- DONE: out_valid=1 and y = node[out_sel]. On out_ready, go to IDLE.
- Node reads:
  - A gate not yet evaluated in this pass reads 0, because values are cleared at accept.
  - An index beyond N_IN+N_GATES reads 0.
  - num_gates>N_GATES is clamped to N_GATES.
- prog_we and cfg_we outside IDLE are ignored. They are not queued.
- A simultaneous prog_we and in_valid in IDLE are both accepted. The write updates memory in that cycle, and the accepted vector uses the new program.
- Reset values:
  - State IDLE; out_valid=0; y=0; in_ready=1; prog_ready=1.
  - num_gates=0, out_sel=0, every gate word=0, so every gate is MAJ(0,0,0)=0.
- Reset during EVAL or DONE aborts the pass and drops the result.

## Timing
- Accept at cycle T gives out_valid at T+1+num_gates. The minimum is T+1 when num_gates=0.
- y and out_valid are registered. y is held stable until the out_ready handshake.
- in_ready returns the cycle after the output handshake. Throughput is 1 vector per num_gates+2 cycles.
- A program or config write takes effect for any vector accepted in the same cycle or later.

## Structure
- Package mig_pkg holds:
  - the operand struct {inv, idx};
  - the gate-word struct {op_c, op_b, op_a};
  - the FSM state enum;
  - a function maj3(a,b,c).
- Sub-module mig_node_mux: selects a node value from const/x/gate vector by index. It is instantiated three times, once per operand, in the EVAL datapath. A fourth instance drives the out_sel result.

## Test plan
- Reset defaults, then x=7'h7F accepted → y=0 at T+1, because out_sel=0 selects constant 0.
- Load a 6-gate program:
  - g0=MAJ(x0,x2,x5); g1=MAJ(x2,x6,g0); g2=MAJ(x1,x4,g0)
  - g3=MAJ(x0,x1,g2); g4=MAJ(x6,g1,g2); g5=MAJ(x3,g3,g4)
  - out_sel=g5
  - Expected: x=7'b0001011 → y=1 at T+7; x=7'b0000011 → y=0; x=0 → y=0.
- Inversion: g0=MAJ(x1,x2,~node0), i.e. OR. x=7'b0000010 → y=1; x=0 → y=0. Changing to MAJ(~x1,~x2,node0) (NOR of x1,x2) with x=0 → y=1.
- Backpressure: hold out_ready=0 for 10 cycles → out_valid and y stable, in_ready=0, and prog_we during DONE leaves memory unchanged (verified by readback through the next evaluation).
- Forward reference: g0=MAJ(g1,~node0,x0), g1=MAJ(~node0,~node0,node0)=1. g0 reads g1=0, so y(out_sel=g0)=x0.
- rst asserted mid-EVAL → next cycle out_valid=0, in_ready=1, num_gates=0. The following accept gives y=0 at T+1.
